// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial adder/subtractor controller:
// FSM state encoding and the default operand width.
package serial_addsub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_addsub_ctrl_fa_nand.sv
// Purely combinational 1-bit full adder built only from 2-input NAND gates.
// Instantiated once by serial_addsub_ctrl and time-shared across all bits.
module fa_nand (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sout,
   output logic cout
);

   logic n1, n2, n3, x1, n4, n5, n6;

   // Classic 9-NAND full adder: first half-adder XOR, second XOR with cin.
   assign n1   = ~(a & b);
   assign n2   = ~(a & n1);
   assign n3   = ~(b & n1);
   assign x1   = ~(n2 & n3);
   assign n4   = ~(x1 & cin);
   assign n5   = ~(x1 & n4);
   assign n6   = ~(cin & n4);
   assign sout = ~(n5 & n6);
   assign cout = ~(n4 & n1);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller driving a single fa_nand cell LSB-first.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub_ctrl
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t state_reg, state_next;

   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] a_sr_reg, b_sr_reg, result_reg;
   logic             carry_reg, cout_reg;
   logic             load, step, last;
   logic             fa_sum, fa_co;

   fa_nand u_fa (
      .a    (a_sr_reg[0]),
      .b    (b_sr_reg[0]),
      .cin  (carry_reg),
      .sout (fa_sum),
      .cout (fa_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start) state_next = S_RUN;
         S_RUN:   if (cnt_reg == LAST_BIT) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      load = (state_reg == S_IDLE) && start;
      step = (state_reg == S_RUN);
      last = step && (cnt_reg == LAST_BIT);
      busy = (state_reg == S_RUN) || (state_reg == S_DONE);
      done = (state_reg == S_DONE);
   end

   // Subtract is a + ~b + 1: invert B at load and seed the carry with 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg    <= '0;
         a_sr_reg   <= '0;
         b_sr_reg   <= '0;
         carry_reg  <= 1'b0;
         result_reg <= '0;
         cout_reg   <= 1'b0;
      end else if (load) begin
         cnt_reg    <= '0;
         a_sr_reg   <= a;
         b_sr_reg   <= sub ? ~b : b;
         carry_reg  <= sub;
         result_reg <= '0;
         cout_reg   <= 1'b0;
      end else if (step) begin
         cnt_reg    <= cnt_reg + CW'(1);
         a_sr_reg   <= a_sr_reg >> 1;
         b_sr_reg   <= b_sr_reg >> 1;
         carry_reg  <= fa_co;
         result_reg <= {fa_sum, result_reg[WIDTH-1:1]};
         if (last) cout_reg <= fa_co;
      end
   end

   assign result = result_reg;
   assign cout   = cout_reg;

`ifdef SERIAL_ADDSUB_OVF_EN
   logic carry_msb_reg;

   // Carry into the MSB is the carry flop just before the final RUN edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       carry_msb_reg <= 1'b0;
      else if (load) carry_msb_reg <= 1'b0;
      else if (last) carry_msb_reg <= carry_reg;
   end

   assign ovf = carry_msb_reg ^ cout_reg;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH=8) against an arithmetic
// reference model; define SERIAL_ADDSUB_OVF_EN to also check ovf.
module tb_serial_addsub_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, cout;
   logic [W-1:0] result;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_addsub_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .sub    (sub),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   // Reference: integer arithmetic modulo 256; returns {ovf, cout, result}.
   function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
      int ux, uy, sx, sy, ures, sres;
      logic c, o;
      ux = int'(x);
      uy = int'(y);
      sx = (ux > 127) ? ux - 256 : ux;
      sy = (uy > 127) ? uy - 256 : uy;
      if (s) begin
         ures = ux - uy;
         sres = sx - sy;
         c    = (ux >= uy);
      end else begin
         ures = ux + uy;
         sres = sx + sy;
         c    = (ures > 255);
      end
      o = (sres > 127) || (sres < -128);
      return {o, c, 8'(ures & 255)};
   endfunction

   task automatic check_ovf(input string name, input logic exp);
`ifdef SERIAL_ADDSUB_OVF_EN
      checks++;
      if (ovf !== exp) begin
         failures++;
         $display("FAIL %s ovf: got %b expected %b", name, ovf, exp);
      end
`endif
   endtask

   // One full operation from an idle block; returns observed result/cout.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                         input string name, output logic [7:0] r_got, output logic c_got);
      logic [9:0] exp;
      int lat;
      int pulses;
      exp = model(ta, tb_, ts);
      @(negedge clk);
      start = 1'b1; a = ta; b = tb_; sub = ts;
      @(posedge clk); #1;
      start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL %s accept: busy=%b done=%b expected busy=1 done=0", name, busy, done);
      end
      lat = 0;
      pulses = 0;
      for (int i = 1; i <= W; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            pulses++;
            if (lat == 0) lat = i;
         end
      end
      checks++;
      if (lat != W || pulses != 1) begin
         failures++;
         $display("FAIL %s latency: got %0d (pulses %0d) expected %0d (1)", name, lat, pulses, W);
      end
      r_got = result;
      c_got = cout;
      checks++;
      if (result !== exp[7:0] || cout !== exp[8]) begin
         failures++;
         $display("FAIL %s data: got result=%h cout=%b expected result=%h cout=%b",
                  name, result, cout, exp[7:0], exp[8]);
      end
      check_ovf(name, exp[9]);
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== exp[7:0]) begin
         failures++;
         $display("FAIL %s idle: done=%b busy=%b result=%h expected 0 0 %h",
                  name, done, busy, result, exp[7:0]);
      end
      $display("op %s a=%h b=%h sub=%b -> result=%h cout=%b", name, ta, tb_, ts, r_got, c_got);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 0 || done !== 0 || result !== 0 || cout !== 0) begin
         failures++;
         $display("FAIL reset: busy=%b done=%b result=%h cout=%b expected all 0", busy, done, result, cout);
      end
      check_ovf("reset", 1'b0);
      @(negedge clk);
      rst = 1'b0;
      $display("reset released");
   endtask

   task automatic test_directed();
      logic [7:0] r;
      logic c;
      run_op(8'h3C, 8'h0F, 1'b0, "add_3c_0f", r, c);
      checks++;
      if (r !== 8'h4B || c !== 1'b0) begin
         failures++; $display("FAIL add_3c_0f const: got %h/%b expected 4b/0", r, c);
      end
      run_op(8'hFF, 8'h01, 1'b0, "add_ff_01", r, c);
      checks++;
      if (r !== 8'h00 || c !== 1'b1) begin
         failures++; $display("FAIL add_ff_01 const: got %h/%b expected 00/1", r, c);
      end
      run_op(8'h05, 8'h07, 1'b1, "sub_05_07", r, c);
      checks++;
      if (r !== 8'hFE || c !== 1'b0) begin
         failures++; $display("FAIL sub_05_07 const: got %h/%b expected fe/0", r, c);
      end
      run_op(8'h07, 8'h05, 1'b1, "sub_07_05", r, c);
      checks++;
      if (r !== 8'h02 || c !== 1'b1) begin
         failures++; $display("FAIL sub_07_05 const: got %h/%b expected 02/1", r, c);
      end
      run_op(8'h7F, 8'h01, 1'b0, "add_7f_01", r, c);
      checks++;
      if (r !== 8'h80) begin
         failures++; $display("FAIL add_7f_01 const: got %h expected 80", r);
      end
      run_op(8'h80, 8'h01, 1'b1, "sub_80_01", r, c);
      checks++;
      if (r !== 8'h7F) begin
         failures++; $display("FAIL sub_80_01 const: got %h expected 7f", r);
      end
   endtask

   task automatic test_random();
      logic [7:0] r;
      logic c;
      for (int i = 0; i < 24; i++)
         run_op(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", i), r, c);
   endtask

   task automatic test_ignore_start();
      logic [9:0] e1, e3;
      int pulses;
      e1 = model(8'h5A, 8'h33, 1'b1);
      e3 = model(8'h11, 8'h22, 1'b0);
      @(negedge clk);
      start = 1'b1; a = 8'h5A; b = 8'h33; sub = 1'b1;
      @(posedge clk); #1;            // E0
      start = 1'b0;
      pulses = 0;
      for (int i = 1; i <= W; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) pulses++;
         if (i == 2) begin start = 1'b1; a = 8'hC3; b = 8'h99; sub = 1'b0; end
         if (i == 3) start = 1'b0;
      end
      checks++;
      if (done !== 1'b1 || pulses != 1 || result !== e1[7:0] || cout !== e1[8]) begin
         failures++;
         $display("FAIL ignore_run: done=%b pulses=%0d result=%h cout=%b expected 1 1 %h %b",
                  done, pulses, result, cout, e1[7:0], e1[8]);
      end
      start = 1'b1; a = 8'hEE; b = 8'hDD; sub = 1'b0;
      @(posedge clk); #1;            // E_W+1, start ignored in DONE
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== e1[7:0]) begin
         failures++;
         $display("FAIL ignore_done: busy=%b done=%b result=%h expected 0 0 %h", busy, done, result, e1[7:0]);
      end
      a = 8'h11; b = 8'h22; sub = 1'b0;
      @(posedge clk); #1;            // accepted right after DONE
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || result !== 8'h00) begin
         failures++;
         $display("FAIL accept_after_done: busy=%b result=%h expected 1 00", busy, result);
      end
      pulses = 0;
      for (int i = 1; i <= W; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) pulses++;
      end
      checks++;
      if (done !== 1'b1 || pulses != 1 || result !== e3[7:0]) begin
         failures++;
         $display("FAIL after_done_op: done=%b pulses=%0d result=%h expected 1 1 %h", done, pulses, result, e3[7:0]);
      end
      @(posedge clk); #1;
      $display("ignore_start scenario complete result=%h", result);
   endtask

   task automatic test_mid_reset();
      int pulses;
      logic [7:0] r;
      logic c;
      @(negedge clk);
      start = 1'b1; a = 8'hAB; b = 8'hCD; sub = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 0 || done !== 0 || result !== 0 || cout !== 0) begin
         failures++;
         $display("FAIL mid_reset: busy=%b done=%b result=%h cout=%b expected all 0", busy, done, result, cout);
      end
      check_ovf("mid_reset", 1'b0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < W + 2; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL mid_reset_nodone: got %0d active cycles expected 0", pulses);
      end
      run_op(8'h10, 8'h20, 1'b0, "post_reset", r, c);
      checks++;
      if (r !== 8'h30) begin
         failures++; $display("FAIL post_reset const: got %h expected 30", r);
      end
   endtask

   task automatic test_back_to_back();
      int seen[$];
      int exp_cyc;
      logic [9:0] e;
      e = model(8'h9C, 8'h47, 1'b1);
      @(negedge clk);
      start = 1'b1; a = 8'h9C; b = 8'h47; sub = 1'b1;
      for (int i = 0; i < 3 * (W + 2); i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen.push_back(i);
      end
      start = 1'b0;
      checks++;
      if (seen.size() != 3) begin
         failures++;
         $display("FAIL back_to_back count: got %0d pulses expected 3", seen.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            exp_cyc = W + k * (W + 2);
            checks++;
            if (seen[k] != exp_cyc) begin
               failures++;
               $display("FAIL back_to_back timing %0d: got cycle %0d expected %0d", k, seen[k], exp_cyc);
            end
         end
      end
      checks++;
      if (result !== e[7:0] || cout !== e[8]) begin
         failures++;
         $display("FAIL back_to_back data: got %h/%b expected %h/%b", result, cout, e[7:0], e[8]);
      end
      repeat (2) @(posedge clk);
      $display("back_to_back done pulses=%0d", seen.size());
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_mid_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
